// File: rtl/goertzel_ctrl_pkg.sv
// Shared definitions for the Goertzel sequencing controller: state codes,
// STATUS register bit positions and default sizing.
package goertzel_ctrl_pkg;

  localparam int NF_DEFAULT = 12;
  localparam int CW_DEFAULT = 16;

  // FSM state codes; kept as plain constants so legacy register maps can
  // decode the state field directly.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_COEF  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_SWEEP = 3'd3;
  localparam state_t ST_FIN   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // STATUS register bit positions
  localparam int STAT_CORDIC = 0;
  localparam int STAT_HERZEL = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_BUSY   = 3;
  localparam int STAT_W      = 4;

  function automatic logic is_busy(input state_t s);
    return (s == ST_COEF) || (s == ST_WAIT) || (s == ST_SWEEP) || (s == ST_FIN);
  endfunction

endpackage

// File: rtl/goertzel_ctrl_if.sv
// Bundle of the controller's command, handshake, MAC-issue and status
// signals. The controller takes the master side; the register file,
// CORDIC, MAC and magnitude blocks sit on the slave side.
interface goertzel_ctrl_if
  import goertzel_ctrl_pkg::*;
#(
  parameter int NF  = NF_DEFAULT,
  parameter int CW  = CW_DEFAULT,
  parameter int CHW = $clog2(NF)
);

  logic           start;
  logic           abort;
  logic [CW-1:0]  cfg_num_samp;
  logic           samp_valid;

  logic           cor_req;
  logic [CHW-1:0] cor_ch;
  logic           cor_ack;

  logic           mac_en;
  logic [CHW-1:0] mac_ch;
  logic           mac_first;
  logic           mac_last;

  logic           fin_req;
  logic [CHW-1:0] fin_ch;
  logic           fin_ack;

  logic           busy;
  logic           coef_done;
  logic           all_valid;
  logic           samp_ovf;

  modport master (
    input  start, abort, cfg_num_samp, samp_valid, cor_ack, fin_ack,
    output cor_req, cor_ch, mac_en, mac_ch, mac_first, mac_last,
           fin_req, fin_ch, busy, coef_done, all_valid, samp_ovf
  );

  modport slave (
    output start, abort, cfg_num_samp, samp_valid, cor_ack, fin_ack,
    input  cor_req, cor_ch, mac_en, mac_ch, mac_first, mac_last,
           fin_req, fin_ch, busy, coef_done, all_valid, samp_ovf
  );

endinterface

// File: rtl/goertzel_chan_seq.sv
// Request/acknowledge stepper over channels 0..NF-1. A go pulse raises req
// on channel 0; each accepted ack moves to the next channel, and the ack of
// the last channel drops req and produces a one-cycle done.
module goertzel_chan_seq
  import goertzel_ctrl_pkg::*;
#(
  parameter int NF  = NF_DEFAULT,
  parameter int CHW = $clog2(NF)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           go,
  input  logic           ack,
  output logic           req,
  output logic [CHW-1:0] ch,
  output logic           done
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(NF - 1);

  logic is_last;

  assign is_last = (ch == LAST_CH);
  // done is combinational so the parent FSM leaves its state on the same
  // edge that req drops
  assign done    = req & ack & is_last;

  // req/ch stepper; ch only moves on an accepted handshake, so it stays
  // stable however long the ack is withheld
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      req <= 1'b0;
      ch  <= '0;
    end else if (go) begin
      req <= 1'b1;
      ch  <= '0;
    end else if (req && ack) begin
      if (is_last) begin
        req <= 1'b0;
        ch  <= '0;
      end else begin
        ch  <= ch + 1'b1;
      end
    end
  end

endmodule

// File: rtl/goertzel_ctrl.sv
// Goertzel run sequencer: loads CORDIC coefficients for every channel,
// issues one MAC sweep over all channels per accepted sample, then
// requests the final magnitude of every channel.
//
//   state | meaning
//   IDLE  | no run; waiting for start
//   COEF  | stepping cor_req over channels 0..NF-1
//   WAIT  | coefficients loaded; waiting for the next sample
//   SWEEP | issuing mac_en for channels 0..NF-1 on consecutive cycles
//   FIN   | stepping fin_req over channels 0..NF-1
//   DONE  | results valid; a new start relaunches
module goertzel_ctrl
  import goertzel_ctrl_pkg::*;
#(
  parameter int NF  = NF_DEFAULT,
  parameter int CW  = CW_DEFAULT,
  parameter int CHW = $clog2(NF)
) (
  input  logic           clk,
  input  logic           rst,
  goertzel_ctrl_if.master bus
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(NF - 1);

  state_t            state;
  logic [CW-1:0]     samp_n;
  logic [CW-1:0]     samp_cnt;
  logic [CW-1:0]     cnt_inc;
  logic              last_samp;
  logic              run_ok;
  logic              sweep_end;
  logic              coef_go;
  logic              fin_go;
  logic              cor_done;
  logic              fin_done;

  logic              mac_en_q;
  logic [CHW-1:0]    mac_ch_q;
  logic              mac_first_q;
  logic              mac_last_q;

  logic              coef_done_q;
  logic              all_valid_q;
  logic              samp_ovf_q;
  logic [STAT_W-1:0] status;

  assign cnt_inc   = samp_cnt + CW'(1);
  // the run ends when the count reaches N, so N itself never wraps the counter
  assign last_samp = (cnt_inc == samp_n);
  assign run_ok    = bus.start & ~bus.abort & ((state == ST_IDLE) | (state == ST_DONE));
  assign sweep_end = (state == ST_SWEEP) & (mac_ch_q == LAST_CH);
  assign coef_go   = run_ok;
  assign fin_go    = sweep_end & last_samp & ~bus.abort;

  goertzel_chan_seq #(.NF(NF), .CHW(CHW)) u_coef_seq (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.abort),
    .go   (coef_go),
    .ack  (bus.cor_ack),
    .req  (bus.cor_req),
    .ch   (bus.cor_ch),
    .done (cor_done)
  );

  goertzel_chan_seq #(.NF(NF), .CHW(CHW)) u_fin_seq (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.abort),
    .go   (fin_go),
    .ack  (bus.fin_ack),
    .req  (bus.fin_req),
    .ch   (bus.fin_ch),
    .done (fin_done)
  );

  // run FSM, sample counter, registered MAC issue and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      samp_n      <= '0;
      samp_cnt    <= '0;
      mac_en_q    <= 1'b0;
      mac_ch_q    <= '0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      coef_done_q <= 1'b0;
      all_valid_q <= 1'b0;
      samp_ovf_q  <= 1'b0;
    end else if (bus.abort) begin
      state       <= ST_IDLE;
      samp_cnt    <= '0;
      mac_en_q    <= 1'b0;
      mac_ch_q    <= '0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      coef_done_q <= 1'b0;
      all_valid_q <= 1'b0;
      samp_ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_ok) begin
            state       <= ST_COEF;
            // zero samples would never finish; run a single sweep instead
            samp_n      <= (bus.cfg_num_samp == '0) ? CW'(1) : bus.cfg_num_samp;
            samp_cnt    <= '0;
            coef_done_q <= 1'b0;
            all_valid_q <= 1'b0;
            samp_ovf_q  <= 1'b0;
          end
        end
        ST_COEF: begin
          if (cor_done) begin
            state       <= ST_WAIT;
            coef_done_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.samp_valid) begin
            state       <= ST_SWEEP;
            mac_en_q    <= 1'b1;
            mac_ch_q    <= '0;
            mac_first_q <= (samp_cnt == '0);
            mac_last_q  <= last_samp;
          end
        end
        ST_SWEEP: begin
          // the MAC is shared, so a sample arriving mid-sweep cannot be served
          if (bus.samp_valid) begin
            samp_ovf_q <= 1'b1;
          end
          if (sweep_end) begin
            mac_en_q    <= 1'b0;
            mac_ch_q    <= '0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            samp_cnt    <= cnt_inc;
            state       <= last_samp ? ST_FIN : ST_WAIT;
          end else begin
            mac_ch_q    <= mac_ch_q + 1'b1;
          end
        end
        ST_FIN: begin
          if (fin_done) begin
            state       <= ST_DONE;
            all_valid_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign status[STAT_CORDIC] = coef_done_q;
  assign status[STAT_HERZEL] = all_valid_q;
  assign status[STAT_OVF]    = samp_ovf_q;
  assign status[STAT_BUSY]   = is_busy(state);

  assign bus.coef_done = status[STAT_CORDIC];
  assign bus.all_valid = status[STAT_HERZEL];
  assign bus.samp_ovf  = status[STAT_OVF];
  assign bus.busy      = status[STAT_BUSY];

  assign bus.mac_en    = mac_en_q;
  assign bus.mac_ch    = mac_ch_q;
  assign bus.mac_first = mac_first_q;
  assign bus.mac_last  = mac_last_q;

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl: full runs, overflow, abort, ack stall,
// zero-length run, start/abort collisions and reset during FIN.
module tb_goertzel_ctrl;

  localparam int NF  = 12;
  localparam int CW  = 16;
  localparam int CHW = $clog2(NF);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  goertzel_ctrl_if #(.NF(NF), .CW(CW), .CHW(CHW)) bus ();

  goertzel_ctrl #(.NF(NF), .CW(CW), .CHW(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // monitor bookkeeping (written only by the monitor process)
  int cor_hs = 0, fin_hs = 0, mac_cyc = 0, first_cyc = 0, last_cyc = 0;
  int sweeps = 0, viol = 0;
  int run_sweeps = 0, cor_k = 0, fin_k = 0, mac_k = 0;
  logic prev_cor_req = 1'b0, prev_fin_req = 1'b0, prev_mac_en = 1'b0;

  // written only by the stimulus process
  int   exp_n = 5;
  logic aborting = 1'b0;
  logic cor_stall = 1'b0;
  int   b_cor, b_fin, b_mac, b_first, b_last, b_sweeps, b_viol;

  // responders: ack one cycle after req, then deassert for a cycle
  always @(negedge clk) begin
    bus.cor_ack = bus.cor_req & ~bus.cor_ack & ~(cor_stall & (bus.cor_ch == 4'd7));
    bus.fin_ack = bus.fin_req & ~bus.fin_ack;
  end

  // protocol monitor: channel order, sweep shape, first/last flags
  always @(posedge clk) begin
    if (bus.cor_req === 1'b1 && prev_cor_req !== 1'b1) begin
      cor_k = 0;
      run_sweeps = 0;
    end
    if (bus.fin_req === 1'b1 && prev_fin_req !== 1'b1) fin_k = 0;
    if (bus.cor_req === 1'b1 && bus.cor_ack === 1'b1) begin
      if (bus.cor_ch !== CHW'(cor_k)) viol++;
      cor_k++;
      cor_hs++;
    end
    if (bus.fin_req === 1'b1 && bus.fin_ack === 1'b1) begin
      if (bus.fin_ch !== CHW'(fin_k)) viol++;
      fin_k++;
      fin_hs++;
    end
    if (bus.mac_en === 1'b1) begin
      if (prev_mac_en !== 1'b1) begin
        mac_k = 0;
        run_sweeps++;
        sweeps++;
      end
      if (bus.mac_ch !== CHW'(mac_k)) viol++;
      if (bus.mac_first !== (run_sweeps == 1)) viol++;
      if (bus.mac_last !== (run_sweeps == exp_n)) viol++;
      if (bus.coef_done !== 1'b1) viol++;
      mac_k++;
      mac_cyc++;
      if (bus.mac_first === 1'b1) first_cyc++;
      if (bus.mac_last === 1'b1) last_cyc++;
    end else if (prev_mac_en === 1'b1 && !aborting && mac_k != NF) begin
      viol++;
    end
    prev_cor_req = bus.cor_req;
    prev_fin_req = bus.fin_req;
    prev_mac_en  = bus.mac_en;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.cor_req, bus.cor_ch, bus.mac_en, bus.mac_ch, bus.mac_first,
                bus.mac_last, bus.fin_req, bus.fin_ch, bus.busy, bus.coef_done,
                bus.all_valid, bus.samp_ovf});
  endfunction

  task automatic snapshot();
    b_cor = cor_hs; b_fin = fin_hs; b_mac = mac_cyc; b_first = first_cyc;
    b_last = last_cyc; b_sweeps = sweeps; b_viol = viol;
  endtask

  task automatic do_start(input int n);
    bus.cfg_num_samp = CW'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_samp();
    bus.samp_valid = 1'b1;
    @(negedge clk);
    bus.samp_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic wait_coef(input string tag);
    int t = 0;
    while (bus.coef_done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_coef_done"}, 32'(bus.coef_done), 32'd1);
  endtask

  task automatic feed(input int n, input bit dup);
    for (int i = 0; i < n; i++) begin
      pulse_samp();
      if (dup) begin
        repeat (4) @(negedge clk);
        pulse_samp();
        repeat (34) @(negedge clk);
      end else begin
        repeat (39) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (bus.all_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_all_valid"}, 32'(bus.all_valid), 32'd1);
  endtask

  task automatic check_run(input string tag, input int n, input logic ovf);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_ovf"},    32'(bus.samp_ovf), 32'(ovf));
    check({tag, "_cordone"}, 32'(bus.coef_done), 32'd1);
    check({tag, "_cor_hs"}, 32'(cor_hs - b_cor), 32'd12);
    check({tag, "_fin_hs"}, 32'(fin_hs - b_fin), 32'd12);
    check({tag, "_mac_cyc"}, 32'(mac_cyc - b_mac), 32'(n * 12));
    check({tag, "_first"},  32'(first_cyc - b_first), 32'd12);
    check({tag, "_last"},   32'(last_cyc - b_last), 32'd12);
    check({tag, "_sweeps"}, 32'(sweeps - b_sweeps), 32'(n));
    check({tag, "_viol"},   32'(viol - b_viol), 32'd0);
  endtask

  initial begin
    int t;
    int bad;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.samp_valid = 1'b0;
    bus.cfg_num_samp = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic run, N=5, one sample every 40 cycles
    exp_n = 5;
    snapshot();
    do_start(5);
    check("run1_busy_after_start", 32'(bus.busy), 32'd1);
    check("run1_cor_req", 32'(bus.cor_req), 32'd1);
    wait_coef("run1");
    feed(5, 1'b0);
    wait_done("run1");
    check_run("run1", 5, 1'b0);

    // overflow: extra strobe 5 cycles into every sweep
    exp_n = 5;
    snapshot();
    do_start(5);
    check("ovf_cleared_at_start", 32'(bus.all_valid), 32'd0);
    wait_coef("ovf");
    feed(5, 1'b1);
    wait_done("ovf");
    check_run("ovf", 5, 1'b1);

    // abort during the third sweep, then a clean run
    exp_n = 5;
    snapshot();
    do_start(5);
    wait_coef("abort");
    feed(2, 1'b0);
    pulse_samp();
    repeat (5) @(negedge clk);
    check("abort_in_sweep3", 32'(bus.mac_en), 32'd1);
    check("abort_sweep_count", 32'(sweeps - b_sweeps), 32'd3);
    aborting = 1'b1;
    pulse_abort();
    check("abort_outs", outs(), 32'd0);
    repeat (3) @(negedge clk);
    aborting = 1'b0;
    check("abort_idle_outs", outs(), 32'd0);
    snapshot();
    do_start(5);
    wait_coef("post_abort");
    feed(5, 1'b0);
    wait_done("post_abort");
    check_run("post_abort", 5, 1'b0);

    // ack withheld on channel 7 for 50 cycles
    exp_n = 2;
    snapshot();
    cor_stall = 1'b1;
    do_start(2);
    t = 0;
    while (!(bus.cor_req === 1'b1 && bus.cor_ch === 4'd7) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stall_reached_ch7", 32'(bus.cor_ch), 32'd7);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.cor_req === 1'b1 && bus.cor_ch === 4'd7 &&
            bus.mac_en === 1'b0 && bus.coef_done === 1'b0)) bad++;
    end
    check("stall_hold_cycles_bad", 32'(bad), 32'd0);
    check("stall_cor_hs", 32'(cor_hs - b_cor), 32'd7);
    pulse_samp();
    check("stall_no_mac", 32'(mac_cyc - b_mac), 32'd0);
    cor_stall = 1'b0;
    wait_coef("stall");
    feed(2, 1'b0);
    wait_done("stall");
    check_run("stall", 2, 1'b0);

    // cfg_num_samp = 0 runs exactly one sweep flagged first and last
    exp_n = 1;
    snapshot();
    do_start(0);
    wait_coef("zero");
    feed(1, 1'b0);
    wait_done("zero");
    check_run("zero", 1, 1'b0);

    // start and abort together from DONE: abort wins
    bus.cfg_num_samp = CW'(3);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_outs", outs(), 32'd0);
    repeat (3) @(negedge clk);
    check("start_abort_stays_idle", 32'(bus.cor_req), 32'd0);

    // start while busy is ignored
    exp_n = 3;
    snapshot();
    do_start(3);
    repeat (5) @(negedge clk);
    do_start(7);
    wait_coef("busy_start");
    do_start(7);
    repeat (3) @(negedge clk);
    feed(3, 1'b0);
    wait_done("busy_start");
    check_run("busy_start", 3, 1'b0);

    // start from DONE relaunches; reset during FIN
    exp_n = 1;
    snapshot();
    do_start(1);
    check("relaunch_busy", 32'(bus.busy), 32'd1);
    check("relaunch_all_valid", 32'(bus.all_valid), 32'd0);
    wait_coef("rstfin");
    pulse_samp();
    t = 0;
    while (bus.fin_req !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rstfin_in_fin", 32'(bus.fin_req), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstfin_outs", outs(), 32'd0);
    rst = 1'b0;
    snapshot();
    repeat (5) @(negedge clk);
    check("rstfin_no_handshakes", 32'(fin_hs - b_fin), 32'd0);
    check("rstfin_idle_outs", outs(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
